icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 150 +++++++++++++++
 tb/tb_icache.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the fetcher/memory environment.
interface icache_if;
  logic        in_fetch_ask;
  logic [31:0] in_fetch_addr;
  logic        out_fetch_ready;
  logic [31:0] out_fetch_inst;
  logic        out_mem_ask;
  logic [31:0] out_mem_addr;
  logic        in_mem_ready;
  logic [31:0] in_mem_inst;

  modport slave (
    input  in_fetch_ask, in_fetch_addr, in_mem_ready, in_mem_inst,
    output out_fetch_ready, out_fetch_inst, out_mem_ask, out_mem_addr
  );

  modport master (
    output in_fetch_ask, in_fetch_addr, in_mem_ready, in_mem_inst,
    input  out_fetch_ready, out_fetch_inst, out_mem_ask, out_mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding refill.
// Define ICACHE_PERF_EN to add the out_hit_cnt / out_miss_cnt performance counters.
module icache #(
  parameter int LINE_NUM = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        has_misbranch,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] out_hit_cnt,
  output logic [31:0] out_miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINE_NUM-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [LINE_NUM];
  logic [31:0]       r_data [LINE_NUM];

  logic              r_fetch_ready;
  logic [31:0]       r_fetch_inst;
  logic              r_mem_ask;
  logic [31:0]       r_mem_addr;

  logic              w_fetch_ready_nxt;
  logic [31:0]       w_fetch_inst_nxt;
  logic              w_mem_ask_nxt;
  logic [31:0]       w_mem_addr_nxt;

  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_accept;
  logic              w_refill;
  logic              w_unused;

  assign w_req_idx  = bus.in_fetch_addr[IDX_W+1:2];
  assign w_req_tag  = bus.in_fetch_addr[31:IDX_W+2];
  // The latched refill address doubles as the line-write address.
  assign w_fill_idx = r_mem_addr[IDX_W+1:2];
  assign w_fill_tag = r_mem_addr[31:IDX_W+2];
  assign w_unused   = ^bus.in_fetch_addr[1:0];

  assign w_hit    = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept = rdy && !has_misbranch && (r_state == S_IDLE)
                    && bus.in_fetch_ask && !r_fetch_ready;
  assign w_refill = rdy && !has_misbranch && (r_state == S_MISS) && bus.in_mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (has_misbranch) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && !w_hit) w_state_nxt = S_MISS;
        S_MISS:  if (bus.in_mem_ready)   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_fetch_ready_nxt = 1'b0;
    w_fetch_inst_nxt  = r_fetch_inst;
    w_mem_ask_nxt     = r_mem_ask;
    w_mem_addr_nxt    = r_mem_addr;
    if (has_misbranch) begin
      w_mem_ask_nxt = 1'b0;
    end else if (w_accept) begin
      if (w_hit) begin
        w_fetch_ready_nxt = 1'b1;
        w_fetch_inst_nxt  = r_data[w_req_idx];
      end else begin
        w_mem_ask_nxt  = 1'b1;
        w_mem_addr_nxt = {bus.in_fetch_addr[31:2], 2'b00};
      end
    end else if (w_refill) begin
      w_fetch_ready_nxt = 1'b1;
      w_fetch_inst_nxt  = bus.in_mem_inst;
      w_mem_ask_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_ready <= 1'b0;
      r_fetch_inst  <= 32'h0;
      r_mem_ask     <= 1'b0;
      r_mem_addr    <= 32'h0;
    end else if (rdy) begin
      r_fetch_ready <= w_fetch_ready_nxt;
      r_fetch_inst  <= w_fetch_inst_nxt;
      r_mem_ask     <= w_mem_ask_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_valid <= '0;
    else if (w_refill) r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag/data storage needs no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.in_mem_inst;
    end
  end

  assign bus.out_fetch_ready = r_fetch_ready;
  assign bus.out_fetch_inst  = r_fetch_inst;
  assign bus.out_mem_ask     = r_mem_ask;
  assign bus.out_mem_addr    = r_mem_addr;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= 32'h0;
      r_miss_cnt <= 32'h0;
    end else if (w_accept) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign out_hit_cnt  = r_hit_cnt;
  assign out_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written flush/stall/reset
// sequences, then randomized fetches checked against a line-by-word-address cache model.
module tb_icache;
  localparam int LN = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy = 1'b1;
  logic has_misbranch = 1'b0;

  icache_if bus();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache #(.LINE_NUM(LN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdy(rdy),
    .has_misbranch(has_misbranch),
    .bus(bus)
`ifdef ICACHE_PERF_EN
    ,
    .out_hit_cnt(hit_cnt),
    .out_miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: each line remembers which word address it holds and its data.
  bit          mv    [LN];
  logic [29:0] mword [LN];
  logic [31:0] mdat  [LN];
  int          exp_hits = 0;
  int          exp_misses = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] mw;
    bit          hit;
    int          wait_n;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 2) % LN);
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return mv[lidx(a)] && (mword[lidx(a)] == a[31:2]);
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LN; i++) mv[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic check_perf(input string nm);
`ifdef ICACHE_PERF_EN
    chk({nm, "_hit_cnt"}, hit_cnt, exp_hits);
    chk({nm, "_miss_cnt"}, miss_cnt, exp_misses);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // One fetch transaction; on a miss, optionally stalls randomly or is flushed.
  task automatic fetch(input logic [31:0] a, input logic [31:0] mw, input bit exp_hit,
                       input int wait_n, input bit flush, input bit stall_rand);
    logic [31:0] waddr;
    waddr = {a[31:2], 2'b00};
    bus.in_fetch_ask = 1'b1;
    bus.in_fetch_addr = a;
    step();
    bus.in_fetch_ask = 1'b0;
    bus.in_fetch_addr = $urandom;
    if (exp_hit) begin
      exp_hits++;
      chk("hit_ready", bus.out_fetch_ready, 1);
      chk("hit_inst", bus.out_fetch_inst, mw);
      chk("hit_no_mem_ask", bus.out_mem_ask, 0);
      step();
      chk("hit_pulse_end", bus.out_fetch_ready, 0);
    end else begin
      exp_misses++;
      chk("miss_ask", bus.out_mem_ask, 1);
      chk("miss_addr", bus.out_mem_addr, waddr);
      chk("miss_no_ready", bus.out_fetch_ready, 0);
      for (int i = 0; i < wait_n; i++) begin
        if (stall_rand && ($urandom_range(0, 1) == 1)) begin
          rdy = 1'b0;
          bus.in_mem_ready = 1'b1;
          bus.in_mem_inst = $urandom;
        end
        step();
        rdy = 1'b1;
        bus.in_mem_ready = 1'b0;
        chk("wait_ask", bus.out_mem_ask, 1);
        chk("wait_addr", bus.out_mem_addr, waddr);
        chk("wait_no_ready", bus.out_fetch_ready, 0);
      end
      if (flush) begin
        has_misbranch = 1'b1;
        step();
        has_misbranch = 1'b0;
        chk("flush_ask", bus.out_mem_ask, 0);
        chk("flush_no_ready", bus.out_fetch_ready, 0);
        bus.in_mem_ready = 1'b1;
        bus.in_mem_inst = mw;
        step();
        bus.in_mem_ready = 1'b0;
        chk("late_no_ready", bus.out_fetch_ready, 0);
        chk("late_no_ask", bus.out_mem_ask, 0);
      end else begin
        bus.in_mem_ready = 1'b1;
        bus.in_mem_inst = mw;
        step();
        bus.in_mem_ready = 1'b0;
        chk("fill_ready", bus.out_fetch_ready, 1);
        chk("fill_inst", bus.out_fetch_inst, mw);
        chk("fill_ask_drop", bus.out_mem_ask, 0);
        mv[lidx(a)] = 1'b1;
        mword[lidx(a)] = a[31:2];
        mdat[lidx(a)] = mw;
        step();
        chk("fill_pulse_end", bus.out_fetch_ready, 0);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] mw;
    bit          h;

    tv[0] = '{32'h0000_0004, 32'h0000_0013, 1'b0, 0};
    tv[1] = '{32'h0000_0004, 32'h0000_0013, 1'b1, 0};
    tv[2] = '{32'h0000_0404, 32'hAAAA_0404, 1'b0, 1};
    tv[3] = '{32'h0000_0004, 32'h0000_0013, 1'b0, 0};
    tv[4] = '{32'h0000_0404, 32'hAAAA_0404, 1'b0, 3};
    tv[5] = '{32'h0000_0004, 32'h0000_0013, 1'b0, 2};
    tv[6] = '{32'h0000_0004, 32'h0000_0013, 1'b1, 0};

    bus.in_fetch_ask = 1'b0;
    bus.in_fetch_addr = 32'h0;
    bus.in_mem_ready = 1'b0;
    bus.in_mem_inst = 32'h0;
    model_clear();

    #2 rst_n = 1'b0;
    #10;
    chk("rst_ready", bus.out_fetch_ready, 0);
    chk("rst_inst", bus.out_fetch_inst, 0);
    chk("rst_mem_ask", bus.out_mem_ask, 0);
    chk("rst_mem_addr", bus.out_mem_addr, 0);
    check_perf("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      fetch(tv[i].addr, tv[i].mw, tv[i].hit, tv[i].wait_n, 1'b0, 1'b0);
      if (i == 1) check_perf("cold_then_hit");
    end

    // Flush while a refill is outstanding; the earlier line must survive.
    fetch(32'h0000_0008, 32'h0000_0022, 1'b0, 1, 1'b1, 1'b0);
    fetch(32'h0000_0004, 32'h0000_0013, 1'b1, 0, 1'b0, 1'b0);
    fetch(32'h0000_0008, 32'h0000_0022, 1'b0, 0, 1'b0, 1'b0);

    // Request in the same cycle as a flush is not accepted.
    bus.in_fetch_ask = 1'b1;
    bus.in_fetch_addr = 32'h0000_0040;
    has_misbranch = 1'b1;
    step();
    bus.in_fetch_ask = 1'b0;
    has_misbranch = 1'b0;
    chk("mb_same_cycle_ask", bus.out_mem_ask, 0);
    chk("mb_same_cycle_ready", bus.out_fetch_ready, 0);
    step();
    chk("mb_same_cycle_ask2", bus.out_mem_ask, 0);

    // Stall for three cycles in MISS with a memory pulse that must be ignored.
    bus.in_fetch_ask = 1'b1;
    bus.in_fetch_addr = 32'h0000_0020;
    step();
    bus.in_fetch_ask = 1'b0;
    exp_misses++;
    chk("stall_miss_ask", bus.out_mem_ask, 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_mem_ready = (i == 1);
      bus.in_mem_inst = 32'hDEAD_BEEF;
      step();
      bus.in_mem_ready = 1'b0;
      chk("stall_ask", bus.out_mem_ask, 1);
      chk("stall_addr", bus.out_mem_addr, 32'h0000_0020);
      chk("stall_no_ready", bus.out_fetch_ready, 0);
    end
    rdy = 1'b1;
    step();
    chk("post_stall_ask", bus.out_mem_ask, 1);
    chk("post_stall_no_ready", bus.out_fetch_ready, 0);
    bus.in_mem_ready = 1'b1;
    bus.in_mem_inst = 32'h0000_0055;
    step();
    bus.in_mem_ready = 1'b0;
    chk("stall_fill_ready", bus.out_fetch_ready, 1);
    chk("stall_fill_inst", bus.out_fetch_inst, 32'h0000_0055);
    mv[lidx(32'h20)] = 1'b1;
    mword[lidx(32'h20)] = 30'h8;
    mdat[lidx(32'h20)] = 32'h0000_0055;
    step();

    // Memory pulse while idle is ignored; instruction output holds.
    bus.in_mem_ready = 1'b1;
    bus.in_mem_inst = 32'h1111_2222;
    step();
    bus.in_mem_ready = 1'b0;
    chk("idle_mem_ready_ready", bus.out_fetch_ready, 0);
    chk("idle_mem_ready_inst", bus.out_fetch_inst, 32'h0000_0055);
    chk("idle_mem_ready_ask", bus.out_mem_ask, 0);
    fetch(32'h0000_0020, 32'h0000_0055, mhit(32'h20), 0, 1'b0, 1'b0);
    check_perf("directed");

    // Reset during MISS abandons the refill and invalidates every line.
    bus.in_fetch_ask = 1'b1;
    bus.in_fetch_addr = 32'h0000_0010;
    step();
    bus.in_fetch_ask = 1'b0;
    chk("pre_reset_ask", bus.out_mem_ask, 1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_rst_ask", bus.out_mem_ask, 0);
    chk("async_rst_addr", bus.out_mem_addr, 0);
    chk("async_rst_inst", bus.out_fetch_inst, 0);
    chk("async_rst_ready", bus.out_fetch_ready, 0);
    check_perf("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    fetch(32'h0000_0004, 32'h0000_0013, mhit(32'h4), 0, 1'b0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      h = mhit(a);
      mw = h ? mdat[lidx(a)] : memval(a);
      fetch(a, mw, h, $urandom_range(0, 3), !h && ($urandom_range(0, 5) == 0), 1'b1);
    end
    check_perf("random");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
